// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Y86-64 pipeline write-back stage. Holds the W pipeline register, drives the
// register-file write ports (also the W-side forwarding sources for decode),
// reports program status and freezes the pipeline tail on the first retiring
// exception (HLT, ADR or INS).
//
// Optional feature: define WB_INSTRET_EN to add a retired-instruction counter
// (instret_o). The counter counts only instructions that retire with stat AOK.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_n_i        synchronous active-low reset
//   W_stall_i      hold the W register contents
//   W_bubble_i     load a bubble into the W register (stall has priority)
//   M_stat_i       memory-stage status (BUB=0, AOK=1, HLT=2, ADR=3, INS=4)
//   M_icode_i      memory-stage icode
//   M_dstE_i       memory-stage E destination (RNONE=4'hF)
//   M_valE_i       memory-stage E value
//   M_dstM_i       memory-stage M destination
//   m_valM_i       data-memory read value
//   W_icode_o      registered icode
//   W_stat_o       registered status
//   W_dstE_o       E write register, forced to RNONE unless W stat is AOK
//   W_valE_o       registered valE
//   W_dstM_o       M write register, forced to RNONE unless W stat is AOK
//   W_valM_o       registered valM
//   stat_o         program status (BUB reported as AOK)
//   halt_o         pipeline halted
//   retire_o       one-cycle pulse per instruction entering W
//   instret_o      retired AOK instruction count (WB_INSTRET_EN only)
// -----------------------------------------------------------------------------
module writeback_stage #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              W_stall_i,
    input  logic              W_bubble_i,
    input  logic [3:0]        M_stat_i,
    input  logic [3:0]        M_icode_i,
    input  logic [3:0]        M_dstE_i,
    input  logic [DATA_W-1:0] M_valE_i,
    input  logic [3:0]        M_dstM_i,
    input  logic [DATA_W-1:0] m_valM_i,
    output logic [3:0]        W_icode_o,
    output logic [3:0]        W_stat_o,
    output logic [3:0]        W_dstE_o,
    output logic [DATA_W-1:0] W_valE_o,
    output logic [3:0]        W_dstM_o,
    output logic [DATA_W-1:0] W_valM_o,
    output logic [3:0]        stat_o,
    output logic              halt_o,
    output logic              retire_o
`ifdef WB_INSTRET_EN
    ,
    output logic [CNT_W-1:0]  instret_o
`endif
);

    localparam logic [3:0] STAT_BUB = 4'd0;
    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;
    localparam logic [3:0] INOP     = 4'h1;
    localparam logic [3:0] RNONE    = 4'hF;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                w_load_m;
    logic                w_load_bub;
    logic                w_m_excp;
    logic                w_m_valid;

    logic [3:0]          r_stat;
    logic [3:0]          r_icode;
    logic [3:0]          r_dstE;
    logic [DATA_W-1:0]   r_valE;
    logic [3:0]          r_dstM;
    logic [DATA_W-1:0]   r_valM;
    logic                r_retire;

    // Status classes of the instruction arriving from M.
    assign w_m_excp  = (M_stat_i == STAT_HLT) || (M_stat_i == STAT_ADR) ||
                       (M_stat_i == STAT_INS);
    assign w_m_valid = (M_stat_i == STAT_AOK) || w_m_excp;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and W-register load control. In HALT nothing loads, which
    // is what makes stall and bubble irrelevant there.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        w_load_m     = 1'b0;
        w_load_bub   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!W_stall_i) begin
                    if (W_bubble_i) begin
                        w_load_bub = 1'b1;
                    end else begin
                        w_load_m = 1'b1;
                        if (w_m_excp) begin
                            w_state_next = ST_HALT;
                        end
                    end
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // W pipeline register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_stat   <= STAT_BUB;
            r_icode  <= INOP;
            r_dstE   <= RNONE;
            r_valE   <= '0;
            r_dstM   <= RNONE;
            r_valM   <= '0;
            r_retire <= 1'b0;
        end else begin
            // A pulse only on an actual load, so a stalled instruction
            // retires exactly once.
            r_retire <= w_load_m && w_m_valid;
            if (w_load_bub) begin
                r_stat  <= STAT_BUB;
                r_icode <= INOP;
                r_dstE  <= RNONE;
                r_valE  <= '0;
                r_dstM  <= RNONE;
                r_valM  <= '0;
            end else if (w_load_m) begin
                r_stat  <= M_stat_i;
                r_icode <= M_icode_i;
                r_dstE  <= M_dstE_i;
                r_valE  <= M_valE_i;
                r_dstM  <= M_dstM_i;
                r_valM  <= m_valM_i;
            end
        end
    end

    // Excepting or bubble instructions never write or forward.
    assign W_dstE_o  = (r_stat == STAT_AOK) ? r_dstE : RNONE;
    assign W_dstM_o  = (r_stat == STAT_AOK) ? r_dstM : RNONE;
    assign W_icode_o = r_icode;
    assign W_stat_o  = r_stat;
    assign W_valE_o  = r_valE;
    assign W_valM_o  = r_valM;
    assign stat_o    = (r_stat == STAT_BUB) ? STAT_AOK : r_stat;
    assign halt_o    = (r_state == ST_HALT);
    assign retire_o  = r_retire;

`ifdef WB_INSTRET_EN
    logic [CNT_W-1:0] r_instret;

    // Counts on the cycle the pulse is visible; the halting instruction has
    // a non-AOK stat, so the count naturally holds once halted.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_instret <= '0;
        end else if (r_retire && (r_stat == STAT_AOK)) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed test-plan steps followed by randomized traffic, all checked against
// a behavioural model of the W stage kept in this bench.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          W_stall_i = 1'b0;
    logic          W_bubble_i = 1'b0;
    logic [3:0]    M_stat_i = 4'd0;
    logic [3:0]    M_icode_i = 4'd1;
    logic [3:0]    M_dstE_i = 4'hF;
    logic [DW-1:0] M_valE_i = '0;
    logic [3:0]    M_dstM_i = 4'hF;
    logic [DW-1:0] m_valM_i = '0;
    logic [3:0]    W_icode_o;
    logic [3:0]    W_stat_o;
    logic [3:0]    W_dstE_o;
    logic [DW-1:0] W_valE_o;
    logic [3:0]    W_dstM_o;
    logic [DW-1:0] W_valM_o;
    logic [3:0]    stat_o;
    logic          halt_o;
    logic          retire_o;
`ifdef WB_INSTRET_EN
    logic [CW-1:0] instret_o;
`endif

    writeback_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .W_stall_i  (W_stall_i),
        .W_bubble_i (W_bubble_i),
        .M_stat_i   (M_stat_i),
        .M_icode_i  (M_icode_i),
        .M_dstE_i   (M_dstE_i),
        .M_valE_i   (M_valE_i),
        .M_dstM_i   (M_dstM_i),
        .m_valM_i   (m_valM_i),
        .W_icode_o  (W_icode_o),
        .W_stat_o   (W_stat_o),
        .W_dstE_o   (W_dstE_o),
        .W_valE_o   (W_valE_o),
        .W_dstM_o   (W_dstM_o),
        .W_valM_o   (W_valM_o),
        .stat_o     (stat_o),
        .halt_o     (halt_o),
        .retire_o   (retire_o)
`ifdef WB_INSTRET_EN
        ,
        .instret_o  (instret_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: the instruction currently held in W, plus flags.
    typedef struct {
        logic [3:0]    stat;
        logic [3:0]    icode;
        logic [3:0]    dstE;
        logic [DW-1:0] valE;
        logic [3:0]    dstM;
        logic [DW-1:0] valM;
    } insn_t;

    insn_t m_w;
    bit    m_halted  = 1'b0;
    bit    m_retire  = 1'b0;
    int    m_instret = 0;

    function automatic insn_t bubble_insn();
        insn_t b;
        b.stat = 4'd0; b.icode = 4'd1; b.dstE = 4'hF; b.valE = '0;
        b.dstM = 4'hF; b.valM = '0;
        return b;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at it.
    task automatic model_edge();
        bit stat_valid;
        if (!rst_n_i) begin
            m_w = bubble_insn();
            m_halted = 1'b0;
            m_retire = 1'b0;
            m_instret = 0;
            return;
        end
        if (m_retire && m_w.stat == 4'd1) m_instret = (m_instret + 1) % (1 << CW);
        m_retire = 1'b0;
        if (m_halted || W_stall_i) return;
        if (W_bubble_i) begin
            m_w = bubble_insn();
            return;
        end
        m_w.stat = M_stat_i; m_w.icode = M_icode_i;
        m_w.dstE = M_dstE_i; m_w.valE = M_valE_i;
        m_w.dstM = M_dstM_i; m_w.valM = m_valM_i;
        stat_valid = (M_stat_i >= 4'd1) && (M_stat_i <= 4'd4);
        m_retire = stat_valid;
        if (M_stat_i >= 4'd2 && M_stat_i <= 4'd4) m_halted = 1'b1;
    endtask

    task automatic compare_all();
        bit aok;
        aok = (m_w.stat == 4'd1);
        check("W_icode", 64'(W_icode_o), 64'(m_w.icode));
        check("W_stat",  64'(W_stat_o),  64'(m_w.stat));
        check("W_dstE",  64'(W_dstE_o),  aok ? 64'(m_w.dstE) : 64'hF);
        check("W_valE",  W_valE_o,       m_w.valE);
        check("W_dstM",  64'(W_dstM_o),  aok ? 64'(m_w.dstM) : 64'hF);
        check("W_valM",  W_valM_o,       m_w.valM);
        check("stat",    64'(stat_o),    (m_w.stat == 4'd0) ? 64'd1 : 64'(m_w.stat));
        check("halt",    64'(halt_o),    64'(m_halted));
        check("retire",  64'(retire_o),  64'(m_retire));
`ifdef WB_INSTRET_EN
        check("instret", 64'(instret_o), 64'(m_instret));
`endif
    endtask

    // One clock: edge, settle, advance model, compare everything.
    task automatic tick();
        @(posedge clk_i);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic set_m(input logic [3:0] stat, input logic [3:0] icode,
                         input logic [3:0] dste, input logic [DW-1:0] vale,
                         input logic [3:0] dstm, input logic [DW-1:0] valm);
        M_stat_i = stat; M_icode_i = icode; M_dstE_i = dste;
        M_valE_i = vale; M_dstM_i = dstm; m_valM_i = valm;
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic set_m_random(input logic [3:0] stat);
        set_m(stat, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 15)),
              rnd64(), 4'($urandom_range(0, 15)), rnd64());
    endtask

    initial begin
        m_w = bubble_insn();

        // Reset state.
        rst_n_i = 1'b0;
        tick();
        tick();
        rst_n_i = 1'b1;

        // 1: plain AOK OPq.
        set_m(4'd1, 4'd6, 4'd3, 64'h55, 4'hF, 64'h0);
        tick();
        check("t1_dstE", 64'(W_dstE_o), 64'd3);
        check("t1_valE", W_valE_o, 64'h55);
        check("t1_retire", 64'(retire_o), 64'd1);

        // 2: mrmovq, then stalled for three cycles with new M inputs.
        set_m(4'd1, 4'd5, 4'hF, 64'h10, 4'd2, 64'hAB);
        tick();
        W_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_m_random(4'd1);
            tick();
            check("t2_dstM_held", 64'(W_dstM_o), 64'd2);
            check("t2_valM_held", W_valM_o, 64'hAB);
            check("t2_no_pulse", 64'(retire_o), 64'd0);
        end

        // 3: stall beats bubble; then bubble alone.
        W_bubble_i = 1'b1;
        set_m_random(4'd1);
        tick();
        check("t3_held", W_valM_o, 64'hAB);
        W_stall_i = 1'b0;
        tick();
        check("t3_bub_icode", 64'(W_icode_o), 64'd1);
        check("t3_bub_stat", 64'(stat_o), 64'd1);
        W_bubble_i = 1'b0;

        // 4: ADR exception halts and freezes the tail.
        set_m(4'd3, 4'd5, 4'hF, 64'h20, 4'd5, 64'h77);
        tick();
        check("t4_dstM_gated", 64'(W_dstM_o), 64'hF);
        check("t4_stat", 64'(stat_o), 64'd3);
        check("t4_halt", 64'(halt_o), 64'd1);
        for (int i = 0; i < 6; i++) begin
            W_stall_i  = 1'($urandom_range(0, 1));
            W_bubble_i = 1'($urandom_range(0, 1));
            set_m_random(4'($urandom_range(0, 4)));
            tick();
            check("t4_frozen", W_valM_o, 64'h77);
        end
        W_stall_i = 1'b0;
        W_bubble_i = 1'b0;

        // 5: reset while halted, then normal retire.
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        check("t5_halt", 64'(halt_o), 64'd0);
        check("t5_Wstat", 64'(W_stat_o), 64'd0);
        set_m_random(4'd1);
        tick();
        check("t5_retire", 64'(retire_o), 64'd1);

        // 6: 17 AOK retires then a HLT retire (counter wraps at CNT_W=4).
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_m_random(4'd1);
            tick();
        end
        set_m_random(4'd2);
        tick();
        tick();
`ifdef WB_INSTRET_EN
        check("t6_instret", 64'(instret_o), 64'd1);
`endif
        check("t6_halt", 64'(halt_o), 64'd1);

        // Randomized traffic with occasional resets to leave HALT.
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst_n_i    = (r >= 3) && !(m_halted && r < 15);
            W_stall_i  = ($urandom_range(0, 99) < 20);
            W_bubble_i = ($urandom_range(0, 99) < 15);
            r = int'($urandom_range(0, 99));
            set_m_random((r < 70) ? 4'd1 : (r < 85) ? 4'd0 : 4'($urandom_range(2, 4)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
